fibo_seq_engine: RTL and testbench
==================================

// Module: fibo_seq_engine
// PURPOSE
//  Parametrised successor to the fixed 4-bit Fibonacci FSM controller: a self-contained
//  sequence engine with an internal adder and term registers. It generates N terms of a
//  Fibonacci-class recurrence T(k)=T(k-1)+T(k-2) mod 2^WIDTH, with selectable seeds.
//  Terms stream out on a valid/ready port; DONE pulses and RESULT holds the last term.
// PARAMETERS
//  WIDTH  16  term/data width in bits
//  CNT_W  8   width of term count N and of OUT_INDEX
// PORTS
//  CLK        in   1      system clock, rising edge
//  RST        in   1      asynchronous reset, active-low
//  START      in   1      request new sequence; sampled only in IDLE
//  MODE       in   2      00 Fibonacci (0,1); 01 Lucas (2,1); 10 custom (SEED0,SEED1); 11 reserved=00
//  N          in   CNT_W  number of terms to emit, captured with START
//  SEED0      in   WIDTH  T(0) for MODE=10, captured with START
//  SEED1      in   WIDTH  T(1) for MODE=10, captured with START
//  OUT_READY  in   1      consumer accepts OUT_DATA this cycle
//  BUSY       out  1      high from START acceptance until the DONE cycle inclusive
//  OUT_VALID  out  1      OUT_DATA/OUT_INDEX/OUT_OVF valid
//  OUT_DATA   out  WIDTH  current term T(OUT_INDEX)
//  OUT_INDEX  out  CNT_W  index k of current term, 0..N-1
//  OUT_OVF    out  1      current term's add produced a carry-out (T(0),T(1) always 0)
//  DONE       out  1      one-cycle pulse at sequence end
//  RESULT     out  WIDTH  last emitted term; held until next START acceptance; 0 if N=0
//  OVERFLOW   out  1      sticky OR of OUT_OVF over emitted terms; cleared on START acceptance
// BEHAVIOUR
//  Reset (RST=0, async): state IDLE; every output 0; internal A,B,idx,N regs 0.
//  Internal regs: A=current term, B=next term, flags fA/fB = carry of each, idx, n.
//  States: IDLE, EMIT, FIN.
//  IDLE: START=1 at edge -> capture N, load A/B from MODE seeds, fA=fB=0, idx=0,
//   clear OVERFLOW and RESULT, BUSY=1; next EMIT if N!=0 else FIN.
//  EMIT: OUT_VALID=1, OUT_DATA=A, OUT_INDEX=idx, OUT_OVF=fA.
//   OUT_READY=0: hold all outputs and registers stable (no change while stalled).
//   OUT_READY=1 and idx==n-1: RESULT<=A, OVERFLOW|=fA, -> FIN.
//   OUT_READY=1 otherwise: A<=B, fA<=fB, {fB,B}<=A+B (WIDTH+1-bit sum, low bits kept),
//   idx<=idx+1, OVERFLOW|=fA; stay EMIT. Throughput 1 term/cycle when READY held high.
//  FIN: DONE=1 for one cycle, BUSY=1, OUT_VALID=0; -> IDLE (BUSY=0 next cycle).
//  Latency: START accepted at edge t -> T(0) valid in cycle after t; READY always high:
//   DONE asserted N+1 cycles after acceptance (N=0: one cycle after).
//  START while BUSY: ignored, no effect on running sequence or captured inputs.
//  START high in the FIN cycle: ignored; accepted earliest in the following IDLE cycle.
//  MODE/N/SEED changes after acceptance: no effect until next acceptance.
//  N=2^CNT_W-1 max; idx never wraps (terminates at n-1).
//  Wrap-around: sum is mod 2^WIDTH; carry reported per term and in sticky OVERFLOW only.
//  Reset mid-sequence: immediate return to IDLE, outputs 0, no DONE pulse.
// TESTING
//  MODE=00, N=10, READY=1 -> OUT_DATA 0,1,1,2,3,5,8,13,21,34 idx 0..9 consecutive; DONE, RESULT=34.
//  MODE=01, N=6, READY toggled 1/0 each cycle -> 2,1,3,4,7,11 each held while READY=0; RESULT=11.
//  WIDTH=8, MODE=00, N=16 -> idx13=233 OVF0, idx14=121 OVF1, idx15=98 OVF1; OVERFLOW=1 after DONE.
//  MODE=10, SEED0=5, SEED1=7, N=4 -> 5,7,12,19; then N=0 START -> DONE next cycle, RESULT=0, no VALID.
//  START pulsed mid-sequence (idx=3 of N=10) -> ignored, sequence completes unchanged.
//  RST low at idx=4 of N=10 -> all outputs 0 immediately, no DONE; new START runs from T(0).

Source files
------------

// File: rtl/fibo_seq_engine.sv
// Parametrised Fibonacci-class sequence engine: T(k)=T(k-1)+T(k-2) mod 2^WIDTH,
// streamed on a valid/ready port with per-term carry, sticky overflow and final result.
module fibo_seq_engine #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       MODE,
    input  logic [CNT_W-1:0] N,
    input  logic [WIDTH-1:0] SEED0,
    input  logic [WIDTH-1:0] SEED1,
    input  logic             OUT_READY,
    output logic             BUSY,
    output logic             OUT_VALID,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic [CNT_W-1:0] OUT_INDEX,
    output logic             OUT_OVF,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             OVERFLOW
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             fa_q, fa_d;
    logic             fb_q, fb_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   sum;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        fa_d     = fa_q;
        fb_d     = fb_q;
        idx_d    = idx_q;
        n_d      = n_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        sum      = {1'b0, a_q} + {1'b0, b_q};

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    n_d = N;
                    case (MODE)
                        2'b01: begin
                            a_d = WIDTH'(2);
                            b_d = WIDTH'(1);
                        end
                        2'b10: begin
                            a_d = SEED0;
                            b_d = SEED1;
                        end
                        default: begin
                            a_d = '0;
                            b_d = WIDTH'(1);
                        end
                    endcase
                    fa_d     = 1'b0;
                    fb_d     = 1'b0;
                    idx_d    = '0;
                    result_d = '0;
                    ovf_d    = 1'b0;
                    state_d  = (N != '0) ? S_EMIT : S_FIN;
                end
            end
            S_EMIT: begin
                // Registers only move on a handshake, so a stalled consumer sees stable data.
                if (OUT_READY) begin
                    ovf_d = ovf_q | fa_q;
                    if (idx_q == n_q - CNT_W'(1)) begin
                        result_d = a_q;
                        state_d  = S_FIN;
                    end else begin
                        a_d   = b_q;
                        fa_d  = fb_q;
                        b_d   = sum[WIDTH-1:0];
                        fb_d  = sum[WIDTH];
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            fa_q     <= 1'b0;
            fb_q     <= 1'b0;
            idx_q    <= '0;
            n_q      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            fa_q     <= fa_d;
            fb_q     <= fb_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign OUT_VALID = (state_q == S_EMIT);
    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = (state_q == S_FIN);
    assign OUT_DATA  = OUT_VALID ? a_q : '0;
    assign OUT_INDEX = OUT_VALID ? idx_q : '0;
    assign OUT_OVF   = OUT_VALID & fa_q;
    assign RESULT    = result_q;
    assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_fibo_seq_engine.sv
// Self-checking bench for fibo_seq_engine: scenario tasks compare the stream against
// an arithmetic reference sequence computed in the bench.
module tb_fibo_seq_engine;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [1:0]  MODE = 2'b00;
    logic [7:0]  N = 8'd0;
    logic [15:0] SEED0 = 16'd0;
    logic [15:0] SEED1 = 16'd0;
    logic        OUT_READY = 1'b0;
    logic        BUSY;
    logic        OUT_VALID;
    logic [15:0] OUT_DATA;
    logic [7:0]  OUT_INDEX;
    logic        OUT_OVF;
    logic        DONE;
    logic [15:0] RESULT;
    logic        OVERFLOW;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_data [0:255];
    bit          exp_ovf  [0:255];
    logic [15:0] exp_result;
    bit          exp_ovf_all;

    fibo_seq_engine #(.WIDTH(16), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .START(START), .MODE(MODE), .N(N),
        .SEED0(SEED0), .SEED1(SEED1), .OUT_READY(OUT_READY),
        .BUSY(BUSY), .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA),
        .OUT_INDEX(OUT_INDEX), .OUT_OVF(OUT_OVF), .DONE(DONE),
        .RESULT(RESULT), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    // Reference: plain integer recurrence, carry when the true sum exceeds 16 bits.
    task automatic build_model(input int mode, input int n, input logic [15:0] s0, input logic [15:0] s1);
        longint t0, t1, s;
        case (mode)
            1: begin t0 = 2; t1 = 1; end
            2: begin t0 = longint'(s0); t1 = longint'(s1); end
            default: begin t0 = 0; t1 = 1; end
        endcase
        exp_ovf_all = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k == 0) begin
                exp_data[k] = 16'(t0);
                exp_ovf[k]  = 1'b0;
            end else if (k == 1) begin
                exp_data[k] = 16'(t1);
                exp_ovf[k]  = 1'b0;
            end else begin
                s = longint'(exp_data[k-1]) + longint'(exp_data[k-2]);
                exp_data[k] = 16'(s % 65536);
                exp_ovf[k]  = (s > 65535);
            end
            exp_ovf_all = exp_ovf_all | exp_ovf[k];
        end
        exp_result = (n == 0) ? 16'd0 : exp_data[n-1];
    endtask

    // rdy_mode: 0 always ready, 1 toggle starting high, 2 random; poke_idx pulses START mid-run.
    task automatic run_sequence(input int mode, input int n, input logic [15:0] s0, input logic [15:0] s1,
                                input int rdy_mode, input int poke_idx, input bit check_idle);
        int k = 0;
        int cyc = 0;
        bit tog = 1'b1;
        bit poked = 1'b0;
        bit run_ovf = 1'b0;
        bit r;
        build_model(mode, n, s0, s1);
        @(negedge CLK);
        START = 1'b1; MODE = 2'(mode); N = 8'(n); SEED0 = s0; SEED1 = s1;
        @(negedge CLK);
        START = 1'b0; MODE = 2'($urandom); N = 8'($urandom); SEED0 = 16'($urandom); SEED1 = 16'($urandom);
        checks++;
        if (RESULT !== 16'd0 || OVERFLOW !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_clear: got result=%0d ovf=%0b expected result=0 ovf=0", RESULT, OVERFLOW);
        end
        while (k < n) begin
            if (cyc > 4 * n + 20) begin
                errors++;
                $display("[TB] FAIL timeout: got %0d terms expected %0d", k, n);
                break;
            end
            checks++;
            if ({OUT_VALID, DONE, BUSY} !== 3'b101) begin
                errors++;
                $display("[TB] FAIL emit_flags k=%0d: got valid/done/busy=%b expected 101", k, {OUT_VALID, DONE, BUSY});
            end
            checks++;
            if (OUT_DATA !== exp_data[k] || OUT_INDEX !== 8'(k)) begin
                errors++;
                $display("[TB] FAIL term k=%0d: got data=%0d idx=%0d expected data=%0d idx=%0d", k, OUT_DATA, OUT_INDEX, exp_data[k], k);
            end
            checks++;
            if (OUT_OVF !== exp_ovf[k] || OVERFLOW !== run_ovf) begin
                errors++;
                $display("[TB] FAIL ovf k=%0d: got ovf=%0b sticky=%0b expected ovf=%0b sticky=%0b", k, OUT_OVF, OVERFLOW, exp_ovf[k], run_ovf);
            end
            r = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = ~tog;
            if (k == poke_idx && !poked) begin
                poked = 1'b1;
                START = 1'b1;
            end
            OUT_READY = r;
            @(negedge CLK);
            START = 1'b0;
            if (r) begin
                run_ovf = run_ovf | exp_ovf[k];
                k++;
            end
            cyc++;
        end
        OUT_READY = 1'b0;
        checks++;
        if ({OUT_VALID, DONE, BUSY} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL fin_flags: got valid/done/busy=%b expected 011", {OUT_VALID, DONE, BUSY});
        end
        checks++;
        if (RESULT !== exp_result || OVERFLOW !== exp_ovf_all) begin
            errors++;
            $display("[TB] FAIL fin_result: got result=%0d ovf=%0b expected result=%0d ovf=%0b", RESULT, OVERFLOW, exp_result, exp_ovf_all);
        end
        if (check_idle) begin
            @(negedge CLK);
            checks++;
            if ({OUT_VALID, DONE, BUSY} !== 3'b000 || RESULT !== exp_result) begin
                errors++;
                $display("[TB] FAIL idle_after: got flags=%b result=%0d expected flags=000 result=%0d", {OUT_VALID, DONE, BUSY}, RESULT, exp_result);
            end
        end
    endtask

    task automatic test_reset;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({BUSY, OUT_VALID, OUT_OVF, DONE, OVERFLOW} !== 5'b0 || OUT_DATA !== 16'd0 || OUT_INDEX !== 8'd0 || RESULT !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got flags=%b data=%0d idx=%0d result=%0d expected all 0",
                     {BUSY, OUT_VALID, OUT_OVF, DONE, OVERFLOW}, OUT_DATA, OUT_INDEX, RESULT);
        end
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_fibonacci;
        run_sequence(0, 10, 16'd0, 16'd0, 0, -1, 1'b1);
        checks++;
        if (RESULT !== 16'd34) begin
            errors++;
            $display("[TB] FAIL fib_result: got %0d expected 34", RESULT);
        end
    endtask

    task automatic test_lucas_stall;
        run_sequence(1, 6, 16'd0, 16'd0, 1, -1, 1'b1);
        checks++;
        if (RESULT !== 16'd11) begin
            errors++;
            $display("[TB] FAIL lucas_result: got %0d expected 11", RESULT);
        end
    endtask

    task automatic test_custom_and_zero;
        run_sequence(2, 4, 16'd5, 16'd7, 0, -1, 1'b1);
        checks++;
        if (RESULT !== 16'd19) begin
            errors++;
            $display("[TB] FAIL custom_result: got %0d expected 19", RESULT);
        end
        run_sequence(2, 0, 16'd5, 16'd7, 0, -1, 1'b1);
    endtask

    task automatic test_wrap;
        run_sequence(0, 30, 16'd0, 16'd0, 2, -1, 1'b1);
        checks++;
        if (OVERFLOW !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_sticky: got %0b expected 1", OVERFLOW);
        end
        run_sequence(3, 20, 16'd0, 16'd0, 0, -1, 1'b1);
    endtask

    task automatic test_start_ignored;
        run_sequence(0, 10, 16'd0, 16'd0, 0, 3, 1'b1);
        run_sequence(0, 2, 16'd0, 16'd0, 0, -1, 1'b0);
        START = 1'b1; MODE = 2'b00; N = 8'd3;
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || OUT_VALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fin_start: got busy=%0b valid=%0b expected busy=0 valid=0", BUSY, OUT_VALID);
        end
        @(negedge CLK);
        START = 1'b0;
        checks++;
        if (BUSY !== 1'b1 || OUT_VALID !== 1'b1 || OUT_DATA !== 16'd0 || OUT_INDEX !== 8'd0) begin
            errors++;
            $display("[TB] FAIL idle_start: got busy=%0b valid=%0b data=%0d idx=%0d expected 1 1 0 0", BUSY, OUT_VALID, OUT_DATA, OUT_INDEX);
        end
        OUT_READY = 1'b1;
        repeat (3) @(negedge CLK);
        OUT_READY = 1'b0;
        checks++;
        if (DONE !== 1'b1 || RESULT !== 16'd1) begin
            errors++;
            $display("[TB] FAIL idle_start_done: got done=%0b result=%0d expected done=1 result=1", DONE, RESULT);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_midseq;
        bit saw_done = 1'b0;
        build_model(0, 10, 16'd0, 16'd0);
        @(negedge CLK);
        START = 1'b1; MODE = 2'b00; N = 8'd10;
        @(negedge CLK);
        START = 1'b0;
        OUT_READY = 1'b1;
        repeat (4) @(negedge CLK);
        checks++;
        if (OUT_INDEX !== 8'd4 || OUT_DATA !== exp_data[4]) begin
            errors++;
            $display("[TB] FAIL pre_reset: got idx=%0d data=%0d expected idx=4 data=%0d", OUT_INDEX, OUT_DATA, exp_data[4]);
        end
        RST = 1'b0;
        #1;
        checks++;
        if ({BUSY, OUT_VALID, OUT_OVF, DONE, OVERFLOW} !== 5'b0 || OUT_DATA !== 16'd0 || OUT_INDEX !== 8'd0 || RESULT !== 16'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got flags=%b data=%0d idx=%0d result=%0d expected all 0",
                     {BUSY, OUT_VALID, OUT_OVF, DONE, OVERFLOW}, OUT_DATA, OUT_INDEX, RESULT);
        end
        @(negedge CLK);
        RST = 1'b1;
        OUT_READY = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            saw_done = saw_done | DONE | BUSY;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_done_after_reset: got activity=%0b expected 0", saw_done);
        end
        run_sequence(0, 10, 16'd0, 16'd0, 0, -1, 1'b1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            run_sequence(int'($urandom_range(0, 3)), int'($urandom_range(0, 40)),
                         16'($urandom), 16'($urandom), 2, -1, 1'b1);
        end
        run_sequence(2, 255, 16'($urandom), 16'($urandom), 0, -1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_fibonacci();
        test_lucas_stall();
        test_custom_and_zero();
        test_wrap();
        test_start_ignored();
        test_reset_midseq();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
